// File: rtl/scatter_lane_reducer.sv
`default_nettype none
// ============================================================================
// Module   : scatter_lane_reducer
// Brief    : N-lane scatter completion tracker plus pipelined charge reducer.
// Revision : 1.0
// ============================================================================
module scatter_lane_reducer #(
  parameter int NUM_LANES = 4,
  parameter int NUM_PORTS = 2,
  parameter int CHARGE_W  = 16,
  parameter int SATURATE  = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start_i,
  input  logic [NUM_LANES-1:0]                      lane_done_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      timeout_o,
  input  logic                                      charge_valid_i,
  input  logic [NUM_LANES*NUM_PORTS*4*CHARGE_W-1:0] charge_i,
  output logic                                      charge_valid_o,
  output logic [NUM_PORTS*4*CHARGE_W-1:0]           charge_o,
  output logic                                      overflow_o
);

  localparam int NPC   = NUM_PORTS * 4;
  localparam int DEPTH = $clog2(NUM_LANES);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_LANES-1:0] ALL_DONE = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;

  // Number of live operands at a given tree level (level 0 = lanes).
  function automatic int lvl_cnt(input int lvl);
    return (NUM_LANES + (1 << lvl) - 1) >> lvl;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          mask_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Restart drops this cycle's lane_done; completion outranks timeout.
        if (start_i) begin
          mask_d = '0;
          cnt_d  = '0;
        end else if ((mask_q | lane_done_i) == ALL_DONE) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          mask_d = mask_q | lane_done_i;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q == RUN);
  assign done_o    = done_q;
  assign timeout_o = timeout_q;

  logic [CHARGE_W-1:0] opnd   [DEPTH+1][NUM_LANES][NPC];
  logic [CHARGE_W-1:0] tree_q [DEPTH][NUM_LANES][NPC];
  logic [CHARGE_W-1:0] tree_d [DEPTH][NUM_LANES][NPC];
  logic [DEPTH-1:0]    vld_q;
  logic [DEPTH:0]      vin;
  logic                ovf_hit;
  logic                ovf_q;
  logic [CHARGE_W:0]   sum;

  assign vin = {vld_q, charge_valid_i};

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int c = 0; c < NPC; c++) begin
        opnd[0][i][c] = charge_i[(i*NPC + c)*CHARGE_W +: CHARGE_W];
        for (int l = 1; l <= DEPTH; l++) begin
          opnd[l][i][c] = tree_q[l-1][i][c];
        end
      end
    end
  end

  always_comb begin
    ovf_hit = 1'b0;
    sum     = '0;
    for (int l = 0; l < DEPTH; l++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        for (int c = 0; c < NPC; c++) begin
          tree_d[l][i][c] = '0;
          if (i < lvl_cnt(l + 1)) begin
            if (2*i + 1 < lvl_cnt(l)) begin
              sum = {1'b0, opnd[l][2*i][c]} + {1'b0, opnd[l][2*i+1][c]};
              if (sum[CHARGE_W]) begin
                tree_d[l][i][c] = (SATURATE != 0) ? '1 : sum[CHARGE_W-1:0];
                if (vin[l]) ovf_hit = 1'b1;
              end else begin
                tree_d[l][i][c] = sum[CHARGE_W-1:0];
              end
            end else begin
              tree_d[l][i][c] = opnd[l][2*i][c];
            end
          end
        end
      end
    end
  end

  // Stages load only on valid beats, so the output holds between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ovf_q <= 1'b0;
      for (int l = 0; l < DEPTH; l++)
        for (int i = 0; i < NUM_LANES; i++)
          for (int c = 0; c < NPC; c++)
            tree_q[l][i][c] <= '0;
    end else begin
      vld_q <= vin[DEPTH-1:0];
      if (ovf_hit) ovf_q <= 1'b1;
      else if (start_i) ovf_q <= 1'b0;
      for (int l = 0; l < DEPTH; l++)
        if (vin[l])
          for (int i = 0; i < NUM_LANES; i++)
            for (int c = 0; c < NPC; c++)
              tree_q[l][i][c] <= tree_d[l][i][c];
    end
  end

  always_comb begin
    charge_o = '0;
    for (int c = 0; c < NPC; c++) begin
      charge_o[c*CHARGE_W +: CHARGE_W] = tree_q[DEPTH-1][0][c];
    end
  end

  assign charge_valid_o = vld_q[DEPTH-1];
  assign overflow_o     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_scatter_lane_reducer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scatter_lane_reducer
// Brief    : Directed self-checking bench; saturating and wrapping instances.
// Revision : 1.0
// ============================================================================
module tb_scatter_lane_reducer;

  localparam int NL  = 4;
  localparam int NP  = 2;
  localparam int CW  = 16;
  localparam int NPC = NP * 4;
  localparam int IW  = NL * NPC * CW;
  localparam int OW  = NPC * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NL-1:0] lane_done;
  logic          charge_valid;
  logic [IW-1:0] charge;

  logic          busy_s, done_s, to_s, cv_s, ov_s;
  logic [OW-1:0] co_s;
  logic          busy_w, done_w, to_w, cv_w, ov_w;
  logic [OW-1:0] co_w;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int to_cnt   = 0;

  always #5 clk = ~clk;

  scatter_lane_reducer #(
    .NUM_LANES(NL), .NUM_PORTS(NP), .CHARGE_W(CW), .SATURATE(1), .TIMEOUT(1024)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .start_i(start), .lane_done_i(lane_done),
    .busy_o(busy_s), .done_o(done_s), .timeout_o(to_s),
    .charge_valid_i(charge_valid), .charge_i(charge),
    .charge_valid_o(cv_s), .charge_o(co_s), .overflow_o(ov_s)
  );

  scatter_lane_reducer #(
    .NUM_LANES(NL), .NUM_PORTS(NP), .CHARGE_W(CW), .SATURATE(0), .TIMEOUT(1024)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .start_i(start), .lane_done_i(lane_done),
    .busy_o(busy_w), .done_o(done_w), .timeout_o(to_w),
    .charge_valid_i(charge_valid), .charge_i(charge),
    .charge_valid_o(cv_w), .charge_o(co_w), .overflow_o(ov_w)
  );

  always @(negedge clk) begin
    if (done_s) done_cnt++;
    if (to_s)   to_cnt++;
  end

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NL-1:0] l);
    lane_done = l;
    tick();
    lane_done = '0;
  endtask

  task automatic do_start(input logic [NL-1:0] l);
    start     = 1'b1;
    lane_done = l;
    tick();
    start     = 1'b0;
    lane_done = '0;
  endtask

  task automatic set_lanes(input logic [CW-1:0] a, b, c, d);
    logic [CW-1:0] v;
    for (int k = 0; k < NL; k++) begin
      v = (k == 0) ? a : (k == 1) ? b : (k == 2) ? c : d;
      for (int cc = 0; cc < NPC; cc++) charge[(k*NPC + cc)*CW +: CW] = v;
    end
  endtask

  function automatic logic [OW-1:0] rep(input logic [CW-1:0] v);
    logic [OW-1:0] r;
    for (int c = 0; c < NPC; c++) r[c*CW +: CW] = v;
    return r;
  endfunction

  function automatic logic [CW-1:0] val(input int b, input int k, input int c);
    return CW'(b*97 + k*13 + c*7 + 1);
  endfunction

  function automatic logic [OW-1:0] exp_beat(input int b);
    logic [OW-1:0] r;
    logic [CW-1:0] s;
    for (int c = 0; c < NPC; c++) begin
      s = '0;
      for (int k = 0; k < NL; k++) s = s + val(b, k, c);
      r[c*CW +: CW] = s;
    end
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, d0, t0;
    rst_n = 1'b0; start = 1'b0; lane_done = '0; charge_valid = 1'b0; charge = '0;
    tick(); tick();
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_timeout", to_s, 0);
    check("rst_cvalid", cv_s, 0);
    check("rst_charge", co_s, 0);
    check("rst_overflow", ov_s, 0);
    rst_n = 1'b1;
    tick();

    // Completion in order 0,2,1,3
    t0 = to_cnt;
    do_start('0);
    check("busy_after_start", busy_s, 1);
    pulse(4'b0001); check("done_early_0", done_s, 0);
    pulse(4'b0100); check("done_early_2", done_s, 0);
    pulse(4'b0010); check("done_early_1", done_s, 0);
    pulse(4'b1000); check("done_pulse", done_s, 1);
    check("busy_after_done", busy_s, 0);
    tick();
    check("done_one_cycle", done_s, 0);
    check("no_timeout_completion", to_cnt - t0, 0);

    // Timeout with only lanes 0,1
    d0 = done_cnt;
    do_start('0);
    pulse(4'b0011);
    n = 1;
    while (n < 1100 && !to_s) begin
      tick();
      n++;
    end
    check("timeout_latency", n, 1024);
    tick();
    check("timeout_one_cycle", to_s, 0);
    check("busy_after_timeout", busy_s, 0);
    check("no_done_on_timeout", done_cnt - d0, 0);

    // Restart discards same-cycle lane 3
    do_start('0);
    do_start(4'b1000);
    pulse(4'b0111); check("restart_drops_lane3", done_s, 0);
    pulse(4'b1000); check("restart_lane3_again", done_s, 1);

    // Restart clears previously collected mask
    do_start('0);
    pulse(4'b1100);
    do_start('0);
    pulse(4'b0011); check("restart_clears_mask", done_s, 0);
    pulse(4'b1100); check("restart_done", done_s, 1);
    tick();

    // Basic sum 1+2+3+4
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    charge_valid = 1'b1;
    tick();
    charge_valid = 1'b0;
    check("sum_not_yet", cv_s, 0);
    tick();
    check("sum_valid", cv_s, 1);
    check("sum_value", co_s, rep(16'd10));
    check("sum_no_overflow", ov_s, 0);
    tick();
    check("sum_valid_drop", cv_s, 0);
    check("sum_hold", co_s, rep(16'd10));

    // Saturate vs wrap
    set_lanes(16'hFFF0, 16'h0020, 16'h0020, 16'h0020);
    charge_valid = 1'b1;
    tick();
    charge_valid = 1'b0;
    tick();
    check("sat_valid", cv_s, 1);
    check("sat_value", co_s, rep(16'hFFFF));
    check("sat_overflow", ov_s, 1);
    check("wrap_valid", cv_w, 1);
    check("wrap_value", co_w, rep(16'h0050));
    check("wrap_overflow", ov_w, 1);
    do_start('0);
    check("sat_ovf_cleared", ov_s, 0);
    check("wrap_ovf_cleared", ov_w, 0);

    // 20 back-to-back beats
    for (int t = 0; t < 22; t++) begin
      if (t < 20) begin
        charge_valid = 1'b1;
        for (int k = 0; k < NL; k++)
          for (int c = 0; c < NPC; c++)
            charge[(k*NPC + c)*CW +: CW] = val(t, k, c);
      end else begin
        charge_valid = 1'b0;
      end
      tick();
      if (t >= 1 && t <= 20) begin
        check($sformatf("tp_valid_%0d", t - 1), cv_s, 1);
        check($sformatf("tp_data_%0d", t - 1), co_s, exp_beat(t - 1));
      end else begin
        check($sformatf("tp_idle_%0d", t), cv_s, 0);
      end
    end

    // Async reset mid-RUN with beats in flight
    check("pre_reset_busy", busy_s, 1);
    set_lanes(16'hFFF0, 16'h0020, 16'h0020, 16'h0020);
    charge_valid = 1'b1;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy_s, 0);
    check("arst_cvalid", cv_s, 0);
    check("arst_charge", co_s, 0);
    check("arst_overflow", ov_s, 0);
    charge_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (cv_s) n++;
    end
    check("arst_no_stale_valid", n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scatter_lane_reducer.md
Name: scatter_lane_reducer

Overview:
- Parametrised N-lane successor to the two-lane scatter combiner; sits between NUM_LANES scatterer instances and the field solver's charge read path.
- Tracks per-lane scatter completion with an FSM and timeout, and issues a single done pulse once every lane has finished.
- Sums per-lane charge read-outs through a registered adder tree, with wrap or saturate mode and a sticky overflow flag.

Parameters:
NUM_LANES, 4, number of scatterer lanes (2..16)
NUM_PORTS, 2, grid read ports per lane; each port carries 4 corner charges
CHARGE_W, 16, unsigned charge width
SATURATE, 1, 1 = clamp sums at 2^CHARGE_W-1; 0 = wrap modulo 2^CHARGE_W
TIMEOUT, 1024, max cycles in RUN before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  begin scatter pass; clears completion mask and overflow flag
lane_done  in  NUM_LANES  per-lane done pulse (bit i = lane i)
busy  out  1  high in RUN
done  out  1  one-cycle pulse when all lanes have reported done
timeout  out  1  one-cycle pulse on RUN abort
charge_valid_in  in  1  all lanes' charge_in valid this cycle (lanes aligned)
charge_in  in  NUM_LANES*NUM_PORTS*4*CHARGE_W  lane-major, then port, then corner; corner 0 in LSBs
charge_valid_out  out  1  charge_out valid
charge_out  out  NUM_PORTS*4*CHARGE_W  reduced sums, port-major, corner 0 in LSBs
overflow  out  1  sticky: any reduced sum exceeded 2^CHARGE_W-1

Behaviour:
- Reset (rst=0, async): state=IDLE; mask=0; counter=0; busy, done, timeout, charge_valid_out, overflow=0; charge_out=0; all tree pipeline valid bits=0.
- FSM states: IDLE, RUN.
  - IDLE + start: go to RUN, mask=0, counter=0, overflow=0.
  - RUN: mask |= lane_done each cycle; counter++.
  - RUN, (mask | lane_done) all ones: done=1 for the next cycle only, go to IDLE.
  - RUN, counter reaches TIMEOUT-1 without completion: timeout=1 for one cycle, go to IDLE.
  - Completion and timeout in the same cycle: completion wins (done only, no timeout).
  - start while in RUN: restart. Mask and counter are cleared, and lane_done from that cycle is discarded.
  - lane_done in IDLE: ignored. Repeated pulses from one lane: idempotent.
- busy = (state==RUN), registered.
- Reduction tree, per (port, corner):
  - Pairwise tree of depth D = ceil(log2(NUM_LANES)), one register stage per level.
  - Latency is D cycles from charge_valid_in to charge_valid_out (D=2 for 4 lanes).
  - Odd operand at a level passes through registered, unchanged.
  - Fully pipelined; accepts a new input every cycle with no backpressure.
  - Internal adders are CHARGE_W+1 bits wide.
  - SATURATE=1: a stage result above max clamps to 2^CHARGE_W-1; clamping propagates through later stages.
  - SATURATE=0: keep the low CHARGE_W bits.
  - In either mode, any stage carry-out on a valid beat sets overflow (cleared only by reset or start).
- charge_out holds its last value when charge_valid_out=0.
- FSM and tree are independent: reads are legal in any state.
- Reset mid-pipeline discards all in-flight beats.

Test Plan:
- Completion (defaults): reset, start, pulse lane_done bits 0,2,1,3 on separate cycles -> busy=1 from the cycle after start; done=1 for exactly one cycle, the cycle after the bit-3 pulse; busy=0 afterwards; timeout never asserts.
- Timeout and restart: start with lanes 0,1 done only -> timeout pulses 1024 cycles after start, done stays 0. Separately, start again mid-RUN with lane 3 pulsing in the same cycle -> mask=0 afterwards, and lane 3 must pulse again before done.
- Basic sum: charge_valid_in=1 with lane values 1,2,3,4 on every corner -> two cycles later charge_valid_out=1, every corner=10, overflow=0.
- Saturation and wrap: SATURATE=1, lanes 0xFFF0 plus 0x0020 x3 -> output 0xFFFF, overflow=1. SATURATE=0, same stimulus -> output 0x0050, overflow=1. A subsequent start clears overflow.
- Throughput: 20 back-to-back beats with distinct per-corner values -> 20 consecutive valid outputs, in order, each matching a reference sum.
- Async reset: assert rst=0 mid-RUN with 2 beats in flight -> all outputs 0 immediately; no charge_valid_out after release.
